// File: rtl/k423_if_stage_pkg.sv
// rtl/k423_if_stage_pkg.sv - shared constants and helpers for the k423 fetch stage
//
// Purpose: widths derived from the core defines, the sequential fetch step and
// a word-alignment helper used when loading redirect targets.
`include "k423_defines.svh"

package k423_if_stage_pkg;

  localparam int IF_ADDR_W = `CORE_ADDR_W;
  localparam int IF_INST_W = `CORE_INST_W;

  // Fetch always advances by one 32-bit instruction word.
  localparam logic [IF_ADDR_W-1:0] IF_PC_STEP = IF_ADDR_W'(4);

  // Clear the byte-offset bits so every request is word aligned.
  function automatic logic [IF_ADDR_W-1:0] if_word_align(input logic [IF_ADDR_W-1:0] a);
    return a & ~IF_ADDR_W'(3);
  endfunction

endpackage

// File: rtl/k423_defines.svh
// rtl/k423_defines.svh - core-wide width and reset-address constants
`ifndef K423_DEFINES_SVH
`define K423_DEFINES_SVH

`define CORE_ADDR_W 32
`define CORE_INST_W 32
`define IF_RST_PC   32'h8000_0000

`endif

// File: rtl/k423_if_stage.sv
// rtl/k423_if_stage.sv - k423 instruction-fetch stage with in-order fetch buffer
//
// Purpose: holds the fetch PC, issues word-aligned requests to instruction
// memory, tracks in-flight and returned instructions in a DEPTH-entry buffer
// (allocate at tail, fill at fill pointer, pop at head) and presents
// {pc, inst} to decode. Redirects from execute flush the buffer; responses
// still owed for flushed requests are counted and discarded on arrival.
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   imem_req_vld_o/_rdy_i/_addr_o     fetch request handshake and address
//   imem_rsp_vld_i/_inst_i            in-order memory response (no back-pressure)
//   ex_redirect_vld_i/_pc_i           taken branch/jump from execute
//   if_stage_vld_o, id_stage_rdy_i    handshake toward decode
//   if_pc_o, if_inst_o                head instruction and its PC
`include "k423_defines.svh"

module k423_if_stage
  import k423_if_stage_pkg::*;
#(
  parameter logic [`CORE_ADDR_W-1:0] RST_PC = `IF_RST_PC,
  parameter int                      DEPTH  = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  output logic                    imem_req_vld_o,
  input  logic                    imem_req_rdy_i,
  output logic [`CORE_ADDR_W-1:0] imem_req_addr_o,
  input  logic                    imem_rsp_vld_i,
  input  logic [`CORE_INST_W-1:0] imem_rsp_inst_i,
  input  logic                    ex_redirect_vld_i,
  input  logic [`CORE_ADDR_W-1:0] ex_redirect_pc_i,
  output logic                    if_stage_vld_o,
  input  logic                    id_stage_rdy_i,
  output logic [`CORE_ADDR_W-1:0] if_pc_o,
  output logic [`CORE_INST_W-1:0] if_inst_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  typedef struct packed {
    logic [`CORE_ADDR_W-1:0] pc;
    logic [`CORE_INST_W-1:0] inst;
    logic                    done;
  } entry_t;

  entry_t                  r_buf [DEPTH];
  logic [`CORE_ADDR_W-1:0] r_pc;
  logic [PTR_W-1:0]        r_head;
  logic [PTR_W-1:0]        r_fill;
  logic [PTR_W-1:0]        r_tail;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        r_unfilled;
  logic [CNT_W-1:0]        r_drop;

  logic [OCC_W-1:0]        w_occ;
  logic                    w_alloc;
  logic                    w_fill;
  logic                    w_discard;
  logic                    w_pop;

  // Flushed-but-owed responses still occupy memory slots, so they count
  // against the buffer capacity until they have drained.
  assign w_occ = {1'b0, r_cnt} + {1'b0, r_drop};

  assign imem_req_vld_o  = ~rst_i & ~ex_redirect_vld_i & (w_occ < OCC_W'(DEPTH));
  assign imem_req_addr_o = r_pc;

  assign if_stage_vld_o  = r_buf[r_head].done & (r_cnt != '0) & ~ex_redirect_vld_i;
  assign if_pc_o         = r_buf[r_head].pc;
  assign if_inst_o       = r_buf[r_head].inst;

  assign w_alloc   = imem_req_vld_o & imem_req_rdy_i;
  assign w_discard = imem_rsp_vld_i & (r_drop != '0);
  assign w_fill    = imem_rsp_vld_i & (r_drop == '0);
  assign w_pop     = if_stage_vld_o & id_stage_rdy_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pc       <= RST_PC;
      r_head     <= '0;
      r_fill     <= '0;
      r_tail     <= '0;
      r_cnt      <= '0;
      r_unfilled <= '0;
      r_drop     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= '0;
      end
    end else if (ex_redirect_vld_i) begin
      // Every outstanding request becomes a response to throw away; one of
      // them may be arriving right now and is consumed in this cycle.
      r_pc       <= if_word_align(ex_redirect_pc_i);
      r_head     <= '0;
      r_fill     <= '0;
      r_tail     <= '0;
      r_cnt      <= '0;
      r_unfilled <= '0;
      r_drop     <= r_drop + r_unfilled - CNT_W'(imem_rsp_vld_i);
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i].done <= 1'b0;
      end
    end else begin
      // Tail and fill never coincide on the same cycle: that would need
      // DEPTH unfilled entries, in which case no request can be issued.
      if (w_alloc) begin
        r_buf[r_tail].pc   <= r_pc;
        r_buf[r_tail].done <= 1'b0;
        r_tail             <= r_tail + PTR_W'(1);
        r_pc               <= r_pc + IF_PC_STEP;
      end
      if (w_fill) begin
        r_buf[r_fill].inst <= imem_rsp_inst_i;
        r_buf[r_fill].done <= 1'b1;
        r_fill             <= r_fill + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      if (w_discard) begin
        r_drop <= r_drop - CNT_W'(1);
      end
      r_cnt      <= r_cnt + CNT_W'(w_alloc) - CNT_W'(w_pop);
      r_unfilled <= r_unfilled + CNT_W'(w_alloc) - CNT_W'(w_fill);
    end
  end

endmodule

// File: tb/tb_k423_if_stage.sv
// tb/tb_k423_if_stage.sv - self-checking bench for k423_if_stage
module tb_k423_if_stage;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        imem_req_vld_o;
  logic        imem_req_rdy_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_vld_i;
  logic [31:0] imem_rsp_inst_i;
  logic        ex_redirect_vld_i;
  logic [31:0] ex_redirect_pc_i;
  logic        if_stage_vld_o;
  logic        id_stage_rdy_i;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;

  always #5 clk = ~clk;

  k423_if_stage #(.RST_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .imem_req_vld_o   (imem_req_vld_o),
    .imem_req_rdy_i   (imem_req_rdy_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_vld_i   (imem_rsp_vld_i),
    .imem_rsp_inst_i  (imem_rsp_inst_i),
    .ex_redirect_vld_i(ex_redirect_vld_i),
    .ex_redirect_pc_i (ex_redirect_pc_i),
    .if_stage_vld_o   (if_stage_vld_o),
    .id_stage_rdy_i   (id_stage_rdy_i),
    .if_pc_o          (if_pc_o),
    .if_inst_o        (if_inst_o)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    bit          done;
  } live_t;

  typedef struct {
    logic [31:0] pc;
    int          due;
    bit          flushed;
  } memreq_t;

  live_t       live_q[$];
  memreq_t     mem_q[$];
  logic [31:0] m_pc;
  int          cyc;
  int          lat_min, lat_max;
  int          rsp_pct, req_rdy_pct;
  bit          prev_rst;
  bit          capture;
  logic [31:0] first_pc;
  int          n_pass, n_chk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic run_cycle(input bit rst, input bit redir, input logic [31:0] tgt, input bit rdy);
    int      flushed;
    bit      e_req, e_if;
    memreq_t m;
    rst_i             = rst;
    ex_redirect_vld_i = redir;
    ex_redirect_pc_i  = tgt;
    id_stage_rdy_i    = rdy;
    imem_req_rdy_i    = ($urandom_range(99) < req_rdy_pct);
    imem_rsp_vld_i    = !rst && (mem_q.size() > 0) && (mem_q[0].due <= cyc) &&
                        ($urandom_range(99) < rsp_pct);
    imem_rsp_inst_i   = imem_rsp_vld_i ? mem_word(mem_q[0].pc) : $urandom;
    #1;
    e_req = 1'b0;
    e_if  = 1'b0;
    if (rst) begin
      chk("rst_req_vld", 32'(imem_req_vld_o), 32'd0);
      if (prev_rst) begin
        chk("rst_req_addr", imem_req_addr_o, RST_PC);
        chk("rst_if_vld", 32'(if_stage_vld_o), 32'd0);
        chk("rst_if_pc", if_pc_o, 32'd0);
        chk("rst_if_inst", if_inst_o, 32'd0);
      end
    end else begin
      flushed = 0;
      foreach (mem_q[i]) if (mem_q[i].flushed) flushed++;
      e_req = !redir && (live_q.size() + flushed < DEPTH);
      e_if  = !redir && (live_q.size() > 0) && live_q[0].done;
      chk("req_vld", 32'(imem_req_vld_o), 32'(e_req));
      chk("req_addr", imem_req_addr_o, m_pc);
      chk("if_vld", 32'(if_stage_vld_o), 32'(e_if));
      if (e_if) begin
        chk("if_pc", if_pc_o, live_q[0].pc);
        chk("if_inst", if_inst_o, live_q[0].inst);
      end
      if (capture && if_stage_vld_o && rdy) begin
        first_pc = if_pc_o;
        capture  = 1'b0;
      end
    end

    if (rst) begin
      live_q.delete();
      mem_q.delete();
      m_pc = RST_PC;
    end else begin
      if (imem_rsp_vld_i) begin
        m = mem_q.pop_front();
        if (!redir && !m.flushed) begin
          for (int i = 0; i < live_q.size(); i++) begin
            if (!live_q[i].done) begin
              live_q[i].done = 1'b1;
              live_q[i].inst = mem_word(m.pc);
              break;
            end
          end
        end
      end
      if (redir) begin
        live_q.delete();
        foreach (mem_q[i]) mem_q[i].flushed = 1'b1;
        m_pc = {tgt[31:2], 2'b00};
      end else begin
        if (e_if && rdy) void'(live_q.pop_front());
        if (e_req && imem_req_rdy_i) begin
          live_q.push_back('{pc: m_pc, inst: 32'd0, done: 1'b0});
          mem_q.push_back('{pc: m_pc, due: cyc + $urandom_range(lat_max, lat_min), flushed: 1'b0});
          m_pc = m_pc + 32'd4;
        end
      end
    end
    prev_rst = rst;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    run_cycle(1'b1, 1'b0, 32'd0, 1'b0);
    run_cycle(1'b1, 1'b0, 32'd0, 1'b0);
  endtask

  initial begin
    n_pass = 0;
    n_chk = 0;
    cyc = 0;
    prev_rst = 1'b0;
    capture = 1'b0;
    first_pc = 32'd0;
    m_pc = RST_PC;
    lat_min = 1; lat_max = 1; rsp_pct = 100; req_rdy_pct = 100;
    rst_i = 1'b1; imem_req_rdy_i = 1'b0; imem_rsp_vld_i = 1'b0; imem_rsp_inst_i = 32'd0;
    ex_redirect_vld_i = 1'b0; ex_redirect_pc_i = 32'd0; id_stage_rdy_i = 1'b0;
    @(negedge clk);

    // L=1, decode always ready: back-to-back fetch from RST_PC.
    do_reset();
    for (int i = 0; i < 20; i++) run_cycle(1'b0, 1'b0, 32'd0, 1'b1);

    // L=3: occupancy bound with flushes absent.
    lat_min = 3; lat_max = 3;
    do_reset();
    for (int i = 0; i < 30; i++) run_cycle(1'b0, 1'b0, 32'd0, 1'b1);

    // Decode stall with a full buffer, then resume.
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 8; i++) run_cycle(1'b0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 10; i++) run_cycle(1'b0, 1'b0, 32'd0, 1'b1);

    // Redirect to a misaligned target with two unfilled entries.
    lat_min = 3; lat_max = 3;
    do_reset();
    run_cycle(1'b0, 1'b0, 32'd0, 1'b1);
    run_cycle(1'b0, 1'b0, 32'd0, 1'b1);
    capture = 1'b1;
    run_cycle(1'b0, 1'b1, 32'h8000_0102, 1'b1);
    #1;
    chk("redir_addr", imem_req_addr_o, 32'h8000_0100);
    for (int i = 0; i < 15; i++) run_cycle(1'b0, 1'b0, 32'd0, 1'b1);
    chk("redir_first_pc", first_pc, 32'h8000_0100);

    // Redirect coinciding with a response and a ready decode.
    lat_min = 2; lat_max = 2;
    do_reset();
    run_cycle(1'b0, 1'b0, 32'd0, 1'b1);
    run_cycle(1'b0, 1'b0, 32'd0, 1'b1);
    run_cycle(1'b0, 1'b0, 32'd0, 1'b1);
    capture = 1'b1;
    run_cycle(1'b0, 1'b1, 32'h8000_0200, 1'b1);
    for (int i = 0; i < 12; i++) run_cycle(1'b0, 1'b0, 32'd0, 1'b1);
    chk("redir_rsp_first_pc", first_pc, 32'h8000_0200);

    // Randomized traffic with redirects, stalls and memory delays.
    lat_min = 1; lat_max = 4; rsp_pct = 70; req_rdy_pct = 80;
    for (int i = 0; i < 600; i++)
      run_cycle(1'b0, ($urandom_range(99) < 5), RST_PC + 32'($urandom_range(255)), ($urandom_range(99) < 70));

    // Mid-stream reset and restart.
    do_reset();
    for (int i = 0; i < 200; i++)
      run_cycle(1'b0, ($urandom_range(99) < 5), 32'h8000_1000 + 32'($urandom_range(255)), ($urandom_range(99) < 70));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
